fir_mac_ctrl: RTL

Sequencer for the FIR tap-serial MAC datapath; runs at 12 MHz.
- Owns the 10-tap × 3-bit input delay chain.
- Drives the coefficient SpSram and the MAC enables (iEnMul/iEnAddAcc) once per input sample.
- Captures the MAC result into a registered FIR output with a one-cycle valid strobe.
- Arbitrates the single-port coefficient SRAM between the tap sequencer and host coefficient writes.

---
 rtl/fir_pkg.sv | 33 +++
 rtl/fir_delay_chain.sv | 44 ++++
 rtl/fir_mac_ctrl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fir_pkg
//  Description : Shared constants and FSM encoding for the FIR tap-serial
//                MAC sequencer and its delay chain.
//  Revision    : 1.0 - initial release
// ============================================================================
package fir_pkg;

  // Datapath geometry
  localparam int NUM_TAP = 10;                // taps per output sample
  localparam int ADDR_W  = 4;                 // coefficient SRAM address width
  localparam int SMP_W   = 3;                 // input sample / delay slice width
  localparam int COEFF_W = 16;                // coefficient width
  localparam int OUT_W   = 16;                // MAC / FIR output width
  localparam int DLY_W   = NUM_TAP * SMP_W;   // packed delay chain width

  // oEnMul -> oEnAddAcc -> capture pipeline depth
  localparam int MAC_LAT = 2;

  // Highest tap address issued to the SRAM
  localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(NUM_TAP - 1);

  // Sequencer state encoding
  localparam int ST_W = 3;
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SHIFT   = 3'd1;
  localparam logic [2:0] ST_FETCH   = 3'd2;
  localparam logic [2:0] ST_DRAIN   = 3'd3;
  localparam logic [2:0] ST_CAPTURE = 3'd4;

endpackage : fir_pkg
`default_nettype wire

// File: rtl/fir_delay_chain.sv
`default_nettype none
// ============================================================================
//  Module      : fir_delay_chain
//  Description : Shift-enabled sample delay line. The newest sample enters at
//                slice 0 (LSBs) and the oldest slice falls off the top.
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_delay_chain
  import fir_pkg::*;
#(
  parameter int DEPTH = NUM_TAP,
  parameter int WIDTH = SMP_W
) (
  input  logic                   iClk,
  input  logic                   iRsn,
  input  logic                   iShift,
  input  logic [WIDTH-1:0]       iSmp,
  output logic [DEPTH*WIDTH-1:0] oDelay
);

  logic [DEPTH*WIDTH-1:0] dly_q;
  logic [DEPTH*WIDTH-1:0] dly_d;

  // Next-state: push the new sample into slice 0 when a shift is requested
  always_comb begin
    dly_d = dly_q;
    if (iShift) begin
      dly_d = {dly_q[DEPTH*WIDTH-WIDTH-1:0], iSmp};
    end
  end

  // Delay line storage, cleared asynchronously
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      dly_q <= '0;
    end else begin
      dly_q <= dly_d;
    end
  end

  assign oDelay = dly_q;

endmodule : fir_delay_chain
`default_nettype wire

// File: rtl/fir_mac_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fir_mac_ctrl
//  Description : Per-sample sequencer for the tap-serial FIR MAC. Shifts the
//                delay chain, walks the coefficient SRAM, pipelines the MAC
//                enables, captures the result and arbitrates host coefficient
//                writes onto the single-port SRAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_mac_ctrl
  import fir_pkg::*;
(
  input  logic               iClk12M,
  input  logic               iRsn,
  // Sample input
  input  logic               iEnSample,
  input  logic [SMP_W-1:0]   iFirIn,
  // Host coefficient write port
  input  logic               iCoeffWr,
  input  logic [ADDR_W-1:0]  iCoeffAddr,
  input  logic [COEFF_W-1:0] iCoeffData,
  output logic               oCoeffWrReady,
  // Coefficient SRAM
  output logic               oCsn,
  output logic               oWrn,
  output logic [ADDR_W-1:0]  oAddr,
  output logic [COEFF_W-1:0] oWrDt,
  // MAC datapath control
  output logic [DLY_W-1:0]   oDelay,
  output logic [ADDR_W-1:0]  oTapIdx,
  output logic               oEnMul,
  output logic               oEnAddAcc,
  output logic               oClrAcc,
  input  logic [OUT_W-1:0]   iMac,
  // FIR result and status
  output logic [OUT_W-1:0]   oFirOut,
  output logic               oFirValid,
  output logic               oBusy,
  output logic               oOverrun
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [ST_W-1:0]    state_q,     state_d;
  logic [ADDR_W-1:0]  tap_q,       tap_d;
  logic               csn_q,       csn_d;
  logic               wrn_q,       wrn_d;
  logic [ADDR_W-1:0]  addr_q,      addr_d;
  logic [COEFF_W-1:0] wrdt_q,      wrdt_d;
  logic               clr_acc_q,   clr_acc_d;
  logic [MAC_LAT-1:0] en_pipe_q,   en_pipe_d;
  logic [ADDR_W-1:0]  tap_idx_q,   tap_idx_d;
  logic [OUT_W-1:0]   fir_out_q,   fir_out_d;
  logic               fir_valid_q, fir_valid_d;
  logic               busy_q,      busy_d;
  logic               overrun_q,   overrun_d;

  logic               w_idle;
  logic               w_start;
  logic               w_rd_issued;

  // --------------------------------------------------------------------------
  // Decodes
  // --------------------------------------------------------------------------
  assign w_idle  = (state_q == ST_IDLE);
  // A sample is only taken in IDLE; it always has priority over a host write
  assign w_start = w_idle && iEnSample;
  // A sequencer read is in flight on the SRAM this cycle (host writes drive
  // oWrn low, so they never qualify)
  assign w_rd_issued = !csn_q && wrn_q;

  // Host may only write while the sequencer is idle and no sample is arriving
  assign oCoeffWrReady = w_idle && !iEnSample;

  // --------------------------------------------------------------------------
  // Delay chain: shifts exactly once per accepted sample, then holds
  // --------------------------------------------------------------------------
  fir_delay_chain #(
    .DEPTH (NUM_TAP),
    .WIDTH (SMP_W)
  ) u_delay_chain (
    .iClk   (iClk12M),
    .iRsn   (iRsn),
    .iShift (w_start),
    .iSmp   (iFirIn),
    .oDelay (oDelay)
  );

  // Sequencer FSM and SRAM port arbitration
  always_comb begin
    state_d     = state_q;
    tap_d       = tap_q;
    csn_d       = 1'b1;
    wrn_d       = 1'b1;
    addr_d      = addr_q;
    wrdt_d      = wrdt_q;
    clr_acc_d   = 1'b0;
    fir_out_d   = fir_out_q;
    fir_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (iEnSample) begin
          // New sample: clear the accumulator while the chain shifts
          state_d   = ST_SHIFT;
          clr_acc_d = 1'b1;
        end else if (iCoeffWr) begin
          // Host write owns the SRAM for exactly this one cycle; the address
          // is passed through unchecked, even beyond the tap range
          csn_d  = 1'b0;
          wrn_d  = 1'b0;
          addr_d = iCoeffAddr;
          wrdt_d = iCoeffData;
        end
      end

      ST_SHIFT: begin
        // Tap counter restarts only here, on entry to FETCH
        tap_d   = '0;
        addr_d  = '0;
        csn_d   = 1'b0;
        state_d = ST_FETCH;
      end

      ST_FETCH: begin
        if (tap_q == LAST_TAP) begin
          // Last address already on the bus; release the SRAM
          state_d = ST_DRAIN;
        end else begin
          tap_d  = tap_q + 1'b1;
          addr_d = tap_q + 1'b1;
          csn_d  = 1'b0;
        end
      end

      ST_DRAIN: begin
        // Reads have stopped, so the multiply stage is high here only for
        // the final tap; its add/acc is issued on this same edge
        if (en_pipe_q[MAC_LAT-2]) begin
          state_d = ST_CAPTURE;
        end
      end

      ST_CAPTURE: begin
        fir_out_d   = iMac;
        fir_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // MAC enable pipeline: read data arrives one cycle after the address, then
  // multiply, then add/accumulate one cycle later
  always_comb begin
    en_pipe_d = {en_pipe_q[MAC_LAT-2:0], w_rd_issued};
    tap_idx_d = w_rd_issued ? addr_q : tap_idx_q;
  end

  // Status: busy mirrors the next state; overrun latches any sample that
  // arrives while a sequence is in flight
  always_comb begin
    busy_d    = (state_d != ST_IDLE);
    overrun_d = overrun_q | (iEnSample & !w_idle);
  end

  // FSM, tap counter and SRAM port registers
  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) begin
      state_q <= ST_IDLE;
      tap_q   <= '0;
      csn_q   <= 1'b1;
      wrn_q   <= 1'b1;
      addr_q  <= '0;
      wrdt_q  <= '0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      csn_q   <= csn_d;
      wrn_q   <= wrn_d;
      addr_q  <= addr_d;
      wrdt_q  <= wrdt_d;
    end
  end

  // MAC control registers
  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) begin
      clr_acc_q <= 1'b0;
      en_pipe_q <= '0;
      tap_idx_q <= '0;
    end else begin
      clr_acc_q <= clr_acc_d;
      en_pipe_q <= en_pipe_d;
      tap_idx_q <= tap_idx_d;
    end
  end

  // Result capture and status registers
  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) begin
      fir_out_q   <= '0;
      fir_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      fir_out_q   <= fir_out_d;
      fir_valid_q <= fir_valid_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign oCsn      = csn_q;
  assign oWrn      = wrn_q;
  assign oAddr     = addr_q;
  assign oWrDt     = wrdt_q;
  assign oTapIdx   = tap_idx_q;
  assign oEnMul    = en_pipe_q[0];
  assign oEnAddAcc = en_pipe_q[MAC_LAT-1];
  assign oClrAcc   = clr_acc_q;
  assign oFirOut   = fir_out_q;
  assign oFirValid = fir_valid_q;
  assign oBusy     = busy_q;
  assign oOverrun  = overrun_q;

endmodule : fir_mac_ctrl
`default_nettype wire
